// File: rtl/div8x4_seq.sv
// div8x4_seq: sequential restoring divider, unsigned DVD_W / DVS_W.
// One quotient bit is produced per clock, with a start/busy/done handshake.
// Optional build macro DIV8X4_DIVZERO_ERR_EN adds div_err_o. With it, a zero
// divisor skips the iterations and returns 0/0 with the error flag set.
//
// state | meaning
// IDLE  | waiting for start_i; results of the last operation held
// BUSY  | one restoring iteration per clock, DVD_W iterations total
// DONE  | final cycle; result registers and done pulse load on the exit edge
module div8x4_seq #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o,
  output logic [DVS_W-1:0] remainder_o
`ifdef DIV8X4_DIVZERO_ERR_EN
  ,
  output logic             div_err_o
`endif
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dividend bits leave from the top while quotient bits enter at the bottom,
  // so after DVD_W iterations this register holds the quotient.
  logic [DVD_W-1:0] shreg_q, shreg_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W:0]   prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
`ifdef DIV8X4_DIVZERO_ERR_EN
  logic             zero_q, zero_d;
  logic             err_q, err_d;
`endif

  // Trial value is the partial remainder shifted left with the next dividend bit.
  logic [DVS_W+1:0] trial;
  logic [DVS_W:0]   diff;
  logic             fits;

  assign trial = {prem_q, shreg_q[DVD_W-1]};
  assign fits  = (trial >= {2'b00, dvs_q});
  assign diff  = trial[DVS_W:0] - {1'b0, dvs_q};

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV8X4_DIVZERO_ERR_EN
    zero_d  = zero_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d = 1'b1;
          quo_d  = shreg_q;
          rem_d  = prem_q[DVS_W-1:0];
`ifdef DIV8X4_DIVZERO_ERR_EN
          err_d  = zero_q;
          if (zero_q) begin
            quo_d = '0;
            rem_d = '0;
          end
`endif
          state_d = IDLE;
        end
        if (start_i) begin
          state_d = BUSY;
          shreg_d = dividend_i;
          dvs_d   = divisor_i;
          prem_d  = '0;
          cnt_d   = CNT_W'(DVD_W - 1);
`ifdef DIV8X4_DIVZERO_ERR_EN
          zero_d  = (divisor_i == '0);
          if (divisor_i == '0) state_d = DONE;
          if (state_q == IDLE) err_d = 1'b0;
`endif
        end
      end
      BUSY: begin
        prem_d  = fits ? diff : trial[DVS_W:0];
        shreg_d = {shreg_q[DVD_W-2:0], fits};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shreg_q <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV8X4_DIVZERO_ERR_EN
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV8X4_DIVZERO_ERR_EN
      zero_q  <= zero_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
`ifdef DIV8X4_DIVZERO_ERR_EN
  assign div_err_o   = err_q;
`endif

endmodule

// File: tb/tb_div8x4_seq.sv
// Self-checking bench for div8x4_seq: directed cases, an exhaustive
// back-to-back sweep and randomized operations against an arithmetic model.
module tb_div8x4_seq;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] quotient_o;
  logic [3:0] remainder_o;
`ifdef DIV8X4_DIVZERO_ERR_EN
  logic       div_err_o;
`endif

  int total = 0;
  int bad   = 0;

  // Last result the model expects the outputs to hold.
  logic [7:0] last_q = 8'h00;
  logic [3:0] last_r = 4'h0;

  always #5 clk_i = ~clk_i;

  div8x4_seq #(.DVD_W(8), .DVS_W(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
`ifdef DIV8X4_DIVZERO_ERR_EN
    ,
    .div_err_o   (div_err_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one clock; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    dividend_i = 8'($urandom);
    divisor_i  = 4'($urandom);
  endtask

  // Wait for done (bounded), counting edges and busy cycles, and watching that
  // the outputs hold the previous expected result while busy.
  task automatic wait_done(output int edges, output int busy_cycles, output bit stable);
    edges       = 0;
    busy_cycles = busy_o ? 1 : 0;
    stable      = 1'b1;
    do begin
      @(posedge clk_i); #1;
      edges++;
      if (busy_o) begin
        busy_cycles++;
        if (quotient_o !== last_q || remainder_o !== last_r) stable = 1'b0;
      end
    end while (done_o !== 1'b1 && edges < 50);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Full operation with model-derived expectations for result, latency and busy width.
  task automatic check_op(input string tag, input logic [7:0] a, input logic [3:0] b);
    int e, bc, el, bce;
    bit st;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ee;
    ee  = 1'b0;
    el  = 9;
    bce = 8;
    if (b == 4'd0) begin
`ifdef DIV8X4_DIVZERO_ERR_EN
      eq = 8'h00; er = 4'h0; ee = 1'b1; el = 1; bce = 0;
`else
      eq = 8'hFF; er = a[3:0];
`endif
    end else begin
      eq = 8'(32'(a) / 32'(b));
      er = 4'(32'(a) % 32'(b));
    end
    launch(a, b);
    chk({tag, "_done_low"}, {31'd0, done_o}, 32'd0);
`ifdef DIV8X4_DIVZERO_ERR_EN
    chk({tag, "_err_clr"}, {31'd0, div_err_o}, 32'd0);
`endif
    wait_done(e, bc, st);
    chk({tag, "_latency"}, e, el);
    chk({tag, "_busy_cycles"}, bc, bce);
    chk({tag, "_hold"}, {31'd0, st}, 32'd1);
    chk({tag, "_quot"}, {24'd0, quotient_o}, {24'd0, eq});
    chk({tag, "_rem"}, {28'd0, remainder_o}, {28'd0, er});
`ifdef DIV8X4_DIVZERO_ERR_EN
    chk({tag, "_err"}, {31'd0, div_err_o}, {31'd0, ee});
`endif
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int  e, bc;
    bit  st, seen;
    reset_i    = 1'b1;
    start_i    = 1'b0;
    dividend_i = 8'd0;
    divisor_i  = 4'd0;
    #2;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_quot", {24'd0, quotient_o}, 32'd0);
    chk("rst_rem",  {28'd0, remainder_o}, 32'd0);
`ifdef DIV8X4_DIVZERO_ERR_EN
    chk("rst_err",  {31'd0, div_err_o}, 32'd0);
`endif
    idle(2);
    reset_i = 1'b0;
    idle(2);

    check_op("d200_7", 8'd200, 4'd7);
    idle(3);
    check_op("d255_15", 8'd255, 4'd15);
    idle(1);
    check_op("d5_9", 8'd5, 4'd9);
    idle(2);

    // Start while busy must be ignored.
    launch(8'd200, 4'd7);
    idle(3);
    dividend_i = 8'd100;
    divisor_i  = 4'd3;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    chk("ign_busy", {31'd0, busy_o}, 32'd1);
    wait_done(e, bc, st);
    chk("ign_latency", e, 5);
    chk("ign_hold", {31'd0, st}, 32'd1);
    chk("ign_quot", {24'd0, quotient_o}, 32'd28);
    chk("ign_rem",  {28'd0, remainder_o}, 32'd4);
    last_q = 8'd28;
    last_r = 4'd4;
    idle(3);
    chk("ign_no_restart", {31'd0, busy_o}, 32'd0);

    // Reset in the 4th BUSY cycle aborts immediately.
    launch(8'd200, 4'd7);
    idle(3);
    reset_i = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_quot", {24'd0, quotient_o}, 32'd0);
    chk("abort_rem",  {28'd0, remainder_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    last_q  = 8'd0;
    last_r  = 4'd0;
    seen    = 1'b0;
    repeat (12) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);
    check_op("d60_5", 8'd60, 4'd5);
    idle(2);

    // Divide by zero, then a normal operation.
    check_op("d77_0", 8'd77, 4'd0);
    idle(3);
`ifdef DIV8X4_DIVZERO_ERR_EN
    chk("err_hold", {31'd0, div_err_o}, 32'd1);
`endif
    check_op("d10_3", 8'd10, 4'd3);
    idle(2);

    // Exhaustive sweep, back-to-back: each start is issued in the done cycle.
    for (int a = 0; a < 256 && bad < 20; a++) begin
      for (int b = 1; b < 16 && bad < 20; b++) begin
        check_op("sweep", 8'(a), 4'(b));
      end
    end
    idle(2);

    // Randomized operations, including zero divisors and random idle gaps.
    for (int i = 0; i < 300 && bad < 20; i++) begin
      check_op("rand", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
